bp_update_queue: RTL and testbench

//  Receiving end of the fetch-stage-2 predictor-update interface (updatePC/NPC/CtrlType/Dir/Counter/En).
//  - Buffers committed-CTI updates, which arrive unthrottled.
//  - Drains each update into the BTB write port and the BPB (2-bit counter) write port.
//  - Fetch-1 lookups own those ports first; a write issues only on a cycle the port reports not busy.
//  - Sits between fetch2's update outputs and the BTB/BPB arrays inside fetch1.

---
 rtl/bp_update_queue_pkg.sv | 32 +++
 rtl/bp_update_queue_fifo.sv | 50 +++++
 rtl/bp_update_queue.sv | 108 ++++++++++
 tb/tb_bp_update_queue.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_update_queue_pkg.sv
// Shared types and counter helpers for the branch-predictor update queue.
// The widths and branch-type codes below mirror the global header values.
package bp_update_queue_pkg;

   localparam int SIZE_PC         = 32;
   localparam int BRANCH_TYPE_LOG = 2;

   localparam logic [BRANCH_TYPE_LOG-1:0] CALL        = 2'd0;
   localparam logic [BRANCH_TYPE_LOG-1:0] RETURN      = 2'd1;
   localparam logic [BRANCH_TYPE_LOG-1:0] JUMP        = 2'd2;
   localparam logic [BRANCH_TYPE_LOG-1:0] COND_BRANCH = 2'd3;

   typedef struct packed {
      logic [SIZE_PC-1:0]         pc;
      logic [SIZE_PC-1:0]         npc;
      logic [BRANCH_TYPE_LOG-1:0] ctype;
      logic [1:0]                 newCnt;
      logic                       needBtb;
      logic                       needBpb;
   } bpUpdEntry_t;

   localparam int ENTRY_W = $bits(bpUpdEntry_t);

   function automatic logic [1:0] sat_inc(input logic [1:0] c);
      return (c == 2'd3) ? 2'd3 : c + 2'd1;
   endfunction

   function automatic logic [1:0] sat_dec(input logic [1:0] c);
      return (c == 2'd0) ? 2'd0 : c - 2'd1;
   endfunction

endpackage

// File: rtl/bp_update_queue_fifo.sv
// Circular storage for pending predictor updates: array plus head/tail/count.
// Pointers wrap naturally at DEPTH (power of 2); count tells full from empty.
module bp_update_fifo
   import bp_update_queue_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int W     = ENTRY_W
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     i_push,
   input  logic                     i_pop,
   input  logic [W-1:0]             i_wdata,
   output logic [W-1:0]             o_rdata,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_full
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_head;
   logic [AW-1:0] r_tail;
   logic [AW:0]   r_count;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (i_push) r_tail <= r_tail + 1'b1;
         if (i_pop)  r_head <= r_head + 1'b1;
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage needs no reset: count alone marks which slots are live.
   always_ff @(posedge clk) begin
      if (i_push) r_mem[r_tail] <= i_wdata;
   end

   assign o_rdata = r_mem[r_head];
   assign o_count = r_count;
   assign o_full  = (r_count == (AW+1)'(DEPTH));

endmodule

// File: rtl/bp_update_queue.sv
// Buffers committed-CTI predictor updates and drains them into the BTB and
// BPB write ports whenever fetch1 leaves those ports idle.
module bp_update_queue
   import bp_update_queue_pkg::*;
#(
   parameter int UPDQ_DEPTH = 8
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [SIZE_PC-1:0]           updatePC_i,
   input  logic [SIZE_PC-1:0]           updateNPC_i,
   input  logic [BRANCH_TYPE_LOG-1:0]   updateCtrlType_i,
   input  logic                         updateDir_i,
   input  logic [1:0]                   updateCounter_i,
   input  logic                         updateEn_i,
   input  logic                         btbBusy_i,
   input  logic                         bpbBusy_i,
   output logic                         btbWrEn_o,
   output logic [SIZE_PC-1:0]           btbWrPC_o,
   output logic [SIZE_PC-1:0]           btbWrTarget_o,
   output logic [BRANCH_TYPE_LOG-1:0]   btbWrType_o,
   output logic                         bpbWrEn_o,
   output logic [SIZE_PC-1:0]           bpbWrPC_o,
   output logic [1:0]                   bpbWrCounter_o,
   output logic [$clog2(UPDQ_DEPTH):0]  count_o,
   output logic                         full_o,
   output logic                         dropped_o
);
   logic [1:0]         w_newCnt;
   logic               w_isCond;
   logic               w_needBtb;
   logic               w_needBpb;
   logic               w_want;
   logic               w_push;
   logic               w_pop;
   logic               w_valid;
   logic               w_full;
   logic               w_btbOk;
   logic               w_bpbOk;
   bpUpdEntry_t        w_inEntry;
   bpUpdEntry_t        w_head;
   logic [ENTRY_W-1:0] w_rdata;
   logic [$clog2(UPDQ_DEPTH):0] w_count;

   logic r_btbDone;
   logic r_bpbDone;
   logic r_dropped;

   assign w_newCnt  = updateDir_i ? sat_inc(updateCounter_i) : sat_dec(updateCounter_i);
   assign w_isCond  = (updateCtrlType_i == COND_BRANCH);
   assign w_needBpb = w_isCond && (w_newCnt != updateCounter_i);
   assign w_needBtb = !w_isCond || updateDir_i;
   // Updates that would write nothing are silently ignored, not dropped.
   assign w_want    = updateEn_i && (w_needBtb || w_needBpb);

   assign w_inEntry = '{pc: updatePC_i, npc: updateNPC_i, ctype: updateCtrlType_i,
                        newCnt: w_newCnt, needBtb: w_needBtb, needBpb: w_needBpb};

   assign w_head  = bpUpdEntry_t'(w_rdata);
   assign w_valid = (w_count != '0);

   assign btbWrEn_o = w_valid && w_head.needBtb && !r_btbDone && !btbBusy_i;
   assign bpbWrEn_o = w_valid && w_head.needBpb && !r_bpbDone && !bpbBusy_i;

   // Head retires once every half it needs is either done or strobing now.
   assign w_btbOk = !w_head.needBtb || r_btbDone || btbWrEn_o;
   assign w_bpbOk = !w_head.needBpb || r_bpbDone || bpbWrEn_o;
   assign w_pop   = w_valid && w_btbOk && w_bpbOk;
   assign w_push  = w_want && (!w_full || w_pop);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_btbDone <= 1'b0;
         r_bpbDone <= 1'b0;
         r_dropped <= 1'b0;
      end else begin
         r_dropped <= w_want && w_full && !w_pop;
         if (w_pop) begin
            r_btbDone <= 1'b0;
            r_bpbDone <= 1'b0;
         end else begin
            if (btbWrEn_o) r_btbDone <= 1'b1;
            if (bpbWrEn_o) r_bpbDone <= 1'b1;
         end
      end
   end

   bp_update_fifo #(.DEPTH(UPDQ_DEPTH), .W(ENTRY_W)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_wdata (w_inEntry),
      .o_rdata (w_rdata),
      .o_count (w_count),
      .o_full  (w_full)
   );

   assign btbWrPC_o      = w_valid ? w_head.pc     : '0;
   assign btbWrTarget_o  = w_valid ? w_head.npc    : '0;
   assign btbWrType_o    = w_valid ? w_head.ctype  : '0;
   assign bpbWrPC_o      = w_valid ? w_head.pc     : '0;
   assign bpbWrCounter_o = w_valid ? w_head.newCnt : '0;
   assign count_o        = w_count;
   assign full_o         = w_full;
   assign dropped_o      = r_dropped;

endmodule

// File: tb/tb_bp_update_queue.sv
// Randomized bench for bp_update_queue against a queue-based reference model,
// plus literal expectations for the directed scenarios.
module tb_bp_update_queue;
   import bp_update_queue_pkg::*;

   localparam int D = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] updatePC_i, updateNPC_i;
   logic [1:0]  updateCtrlType_i;
   logic        updateDir_i;
   logic [1:0]  updateCounter_i;
   logic        updateEn_i, btbBusy_i, bpbBusy_i;
   logic        btbWrEn_o, bpbWrEn_o, full_o, dropped_o;
   logic [31:0] btbWrPC_o, btbWrTarget_o, bpbWrPC_o;
   logic [1:0]  btbWrType_o, bpbWrCounter_o;
   logic [3:0]  count_o;

   bp_update_queue #(.UPDQ_DEPTH(D)) dut (
      .clk(clk), .reset(reset),
      .updatePC_i(updatePC_i), .updateNPC_i(updateNPC_i),
      .updateCtrlType_i(updateCtrlType_i), .updateDir_i(updateDir_i),
      .updateCounter_i(updateCounter_i), .updateEn_i(updateEn_i),
      .btbBusy_i(btbBusy_i), .bpbBusy_i(bpbBusy_i),
      .btbWrEn_o(btbWrEn_o), .btbWrPC_o(btbWrPC_o), .btbWrTarget_o(btbWrTarget_o),
      .btbWrType_o(btbWrType_o), .bpbWrEn_o(bpbWrEn_o), .bpbWrPC_o(bpbWrPC_o),
      .bpbWrCounter_o(bpbWrCounter_o), .count_o(count_o), .full_o(full_o),
      .dropped_o(dropped_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc, npc;
      logic [1:0]  ct, nc;
      bit          btb, bpb;   // halves still owed
   } ment_t;

   ment_t mq[$];
   bit    exp_drop;
   int    checks = 0, errors = 0;
   int    btb_writes = 0, bpb_writes = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input bit en, input logic [1:0] ct, input bit dir, input logic [1:0] cnt,
                        input logic [31:0] pc, input logic [31:0] npc, input bit bb, input bit pb);
      updateEn_i = en; updateCtrlType_i = ct; updateDir_i = dir; updateCounter_i = cnt;
      updatePC_i = pc; updateNPC_i = npc; btbBusy_i = bb; bpbBusy_i = pb;
   endtask

   task automatic drive_rand(input bit en, input bit bb, input bit pb);
      drive(en, 2'($urandom_range(0, 3)), 1'($urandom), 2'($urandom_range(0, 3)),
            $urandom, $urandom, bb, pb);
   endtask

   // Compare all outputs against the model, then advance the model one edge.
   task automatic step();
      bit exp_btb, exp_bpb, popped, need_btb, need_bpb;
      int nc;
      ment_t e;
      @(negedge clk);
      exp_btb = (mq.size() > 0) && mq[0].btb && !btbBusy_i;
      exp_bpb = (mq.size() > 0) && mq[0].bpb && !bpbBusy_i;
      chk("btbWrEn", btbWrEn_o, exp_btb);
      chk("bpbWrEn", bpbWrEn_o, exp_bpb);
      chk("count", count_o, mq.size());
      chk("full", full_o, mq.size() == D);
      chk("dropped", dropped_o, exp_drop);
      if (mq.size() > 0) begin
         chk("btbWrPC", btbWrPC_o, mq[0].pc);
         chk("btbWrTarget", btbWrTarget_o, mq[0].npc);
         chk("btbWrType", btbWrType_o, mq[0].ct);
         chk("bpbWrPC", bpbWrPC_o, mq[0].pc);
         chk("bpbWrCounter", bpbWrCounter_o, mq[0].nc);
      end else begin
         chk("idleData", {btbWrPC_o ^ btbWrTarget_o ^ bpbWrPC_o, btbWrType_o, bpbWrCounter_o} == '0, 1);
      end
      if (reset) begin
         mq.delete();
         exp_drop = 0;
      end else begin
         popped = 0;
         if (exp_btb) begin mq[0].btb = 0; btb_writes++; end
         if (exp_bpb) begin mq[0].bpb = 0; bpb_writes++; end
         if (mq.size() > 0 && !mq[0].btb && !mq[0].bpb) begin
            void'(mq.pop_front());
            popped = 1;
         end
         nc = updateDir_i ? ((updateCounter_i == 3) ? 3 : updateCounter_i + 1)
                          : ((updateCounter_i == 0) ? 0 : updateCounter_i - 1);
         need_bpb = (updateCtrlType_i == COND_BRANCH) && (nc != updateCounter_i);
         need_btb = (updateCtrlType_i != COND_BRANCH) || updateDir_i;
         exp_drop = 0;
         if (updateEn_i && (need_btb || need_bpb)) begin
            // A same-cycle pop has already freed a slot in the model here.
            if (mq.size() < D) begin
               e.pc = updatePC_i; e.npc = updateNPC_i; e.ct = updateCtrlType_i;
               e.nc = 2'(nc); e.btb = need_btb; e.bpb = need_bpb;
               mq.push_back(e);
            end else begin
               exp_drop = 1;
            end
         end
         if (popped) ;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      mq.delete();
      exp_drop = 0;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      reset = 1;
      step(); step();
      reset = 0;

      // Reset/idle
      step(); step();
      chk("rst_count", count_o, 0);
      chk("rst_strobes", {btbWrEn_o, bpbWrEn_o, full_o, dropped_o}, 0);

      // Cond branch cnt=1 taken: both halves next cycle, counter 2
      drive(1, COND_BRANCH, 1, 2'd1, 32'h100, 32'h200, 0, 0);
      step();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      chk("t2_btbEn", btbWrEn_o, 1);
      chk("t2_bpbEn", bpbWrEn_o, 1);
      chk("t2_cnt", bpbWrCounter_o, 2);
      chk("t2_tgt", btbWrTarget_o, 32'h200);
      step();
      chk("t2_count0", count_o, 0);

      // Saturated taken: BTB only
      drive(1, COND_BRANCH, 1, 2'd3, 32'h300, 32'h340, 0, 0);
      step();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      chk("t3_btbOnly", {btbWrEn_o, bpbWrEn_o}, 2'b10);
      step();
      // Saturated not-taken: nothing enqueued
      drive(1, COND_BRANCH, 0, 2'd0, 32'h400, 32'h440, 0, 0);
      step();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      chk("t3_noEnq", count_o, 0);
      chk("t3_noDrop", dropped_o, 0);

      // Return held by btbBusy for 5 cycles, two jumps queued behind it
      drive(1, RETURN, 1, 2'd0, 32'h500, 32'h504, 1, 0);
      step();
      for (int i = 0; i < 5; i++) begin
         drive(i < 2, JUMP, 1, 2'd0, 32'h600 + 32'(i), 32'h700 + 32'(i), 1, 0);
         #1;
         chk("t4_btbHeld", btbWrEn_o, 0);
         step();
      end
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      chk("t4_btbGo", btbWrEn_o, 1);
      chk("t4_type", btbWrType_o, RETURN);
      chk("t4_pc", btbWrPC_o, 32'h500);
      step();
      #1;
      chk("t4_order", btbWrPC_o, 32'h600);
      step(); step();

      // Fill with both ports busy, then overflow
      for (int i = 0; i < D; i++) begin
         drive(1, COND_BRANCH, 1, 2'd1, 32'h1000 + 32'(i), 32'h2000 + 32'(i), 1, 1);
         step();
      end
      chk("t5_full", full_o, 1);
      drive(1, CALL, 1, 2'd0, 32'hdead, 32'hbeef, 1, 1);
      step();
      drive(0, 0, 0, 0, 0, 0, 1, 1);
      #1;
      chk("t5_drop", dropped_o, 1);
      chk("t5_count8", count_o, 8);
      step();
      chk("t5_dropPulse", dropped_o, 0);
      drive(1, CALL, 1, 2'd0, 32'hcafe, 32'hf00d, 0, 0);
      step();
      drive(0, 0, 0, 0, 0, 0, 1, 1);
      #1;
      chk("t5_keep8", count_o, 8);
      chk("t5_noDrop", dropped_o, 0);
      for (int i = 0; i < 12; i++) begin
         drive(0, 0, 0, 0, 0, 0, 0, 0);
         step();
      end
      chk("t5_drained", count_o, 0);

      // Randomized enqueue/drain with random busy
      for (int i = 0; i < 400; i++) begin
         drive_rand(($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 40),
                    ($urandom_range(0, 99) < 40));
         step();
      end
      for (int i = 0; i < 30; i++) begin
         drive(0, 0, 0, 0, 0, 0, 0, 0);
         step();
      end
      chk("rand_drained", count_o, 0);

      // Reset with three pending
      for (int i = 0; i < 3; i++) begin
         drive(1, JUMP, 1, 2'd0, 32'h9000 + 32'(i), 32'h9100, 1, 1);
         step();
      end
      chk("t6_pending3", count_o, 3);
      drive(0, 0, 0, 0, 0, 0, 1, 1);
      reset = 1;
      step();
      reset = 0;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      chk("t6_rstCount", count_o, 0);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("t6_noStrobe", {btbWrEn_o, bpbWrEn_o}, 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
